tcm_receiver_wordalign: RTL and testbench
=========================================

TCM_RECEIVER_WORDALIGN -- requirements
Module: tcm_receiver_wordalign

Interface
REQ-001 Parameter DATA_W, default 10: parallel word width from the deserialiser.
REQ-002 Parameter SYNC_WORDS, default 6: sync pattern length in words.
REQ-003 Parameter SYNC_PATTERN, width DATA_W*SYNC_WORDS, default 60'hFFC00FFC00FFFFF: MSB = oldest received bit.
REQ-004 Parameter LOCK_CNT, default 3: consecutive same-offset hits required to lock.
REQ-005 Parameter LOSS_CNT, default 4: consecutive wrong-offset hits that drop lock.
REQ-006 Port clk  input  1: the only clock; all logic on its rising edge.
REQ-007 Port reset  input  1: synchronous, active-high.
REQ-008 Port realign  input  1: single-cycle request to force return to HUNT.
REQ-009 Port rdat  input  DATA_W: raw unaligned word, one per clk.
REQ-010 Port wdat  output  DATA_W: aligned word.
REQ-011 Port wdat_valid  output  1: high while state is LOCKED.
REQ-012 Port offset  output  OFS_W=max(1,clog2(DATA_W)): current bit offset.
REQ-013 Port state  output  2: 0=HUNT, 1=VERIFY, 2=LOCKED.
REQ-014 Port sync_hit  output  1: one-cycle pulse per detected pattern at any offset.
REQ-015 Port lock_lost  output  1: one-cycle pulse on the LOCKED->HUNT transition.

Function
REQ-016 Shift register sr of DATA_W*(SYNC_WORDS+1) bits; each cycle sr <= {sr shifted up by DATA_W, rdat}.
REQ-017 Window k (k=0..DATA_W-1) = sr[k+DATA_W*SYNC_WORDS-1 : k]; hit_vec[k] registered as (window k == SYNC_PATTERN).
REQ-018 Multiple simultaneous bits in hit_vec: lowest index wins (hit_ofs); sync_hit = |hit_vec, registered alongside.
REQ-019 wdat registered each cycle from the top DATA_W bits of window[offset]; offset 0 latency rdat->wdat = SYNC_WORDS+1 cycles.
REQ-020 HUNT: on any hit, offset <= hit_ofs, match count <= 1, go VERIFY; LOCK_CNT=1 goes directly to LOCKED.
REQ-021 VERIFY: hit at offset increments count; count reaching LOCK_CNT -> LOCKED; hit at another offset -> offset <= hit_ofs, count <= 1, stay VERIFY.
REQ-022 LOCKED: hit at offset clears miss count; hit at another offset increments miss count, offset unchanged; miss count reaching LOSS_CNT -> HUNT with lock_lost pulse.
REQ-023 Cycles with no hit change neither counter in any state (no timeout).
REQ-024 realign high: next state HUNT, counters cleared, offset held; lock_lost pulses only if leaving LOCKED; realign overrides a same-cycle hit.
REQ-025 Counters saturate at their thresholds; widths sized from LOCK_CNT and LOSS_CNT.
REQ-026 offset changes only on the transitions in REQ-020/021; wdat follows the new offset from the next cycle.

Reset
REQ-027 reset high: sr, hit_vec, wdat, offset, counters = 0; state = HUNT; wdat_valid, sync_hit, lock_lost = 0.
REQ-028 reset asserted mid-VERIFY or mid-LOCKED aborts immediately to REQ-027 values with no lock_lost pulse.
REQ-029 Detection restarts after reset deasserts; first possible sync_hit requires SYNC_WORDS full words shifted in.

Verification
REQ-030 Defaults, pattern at bit offset 3 repeated every 20 words, random payload -> sync_hit per pattern, offset=3, LOCKED after third hit, wdat equals payload shifted by 3.
REQ-031 Locked at offset 3, then two patterns at offset 7 and one at offset 3 -> stays LOCKED, miss count cleared, offset=3.
REQ-032 Locked at offset 3, then four consecutive patterns at offset 7 -> lock_lost one-cycle pulse, state HUNT, next hit moves to VERIFY at offset 7.
REQ-033 VERIFY at offset 2 with count 2, pattern at offset 5 -> offset=5, count=1, state VERIFY.
REQ-034 realign pulse while LOCKED coincident with a valid hit -> HUNT, lock_lost pulse, wdat_valid low next cycle.
REQ-035 DATA_W=8, SYNC_WORDS=4, SYNC_PATTERN=32'hF0F0FF00, LOCK_CNT=1 -> lock on first hit, offset range 0..7 all reachable.

Source files
------------

// File: rtl/tcm_receiver_wordalign.sv
// tcm_receiver_wordalign: aligns raw deserialiser words by searching every bit offset for a sync pattern (ports: clk, reset, realign, rdat in; wdat, wdat_valid, offset, state, sync_hit, lock_lost out)
module tcm_receiver_wordalign #(
  parameter int DATA_W = 10,
  parameter int SYNC_WORDS = 6,
  parameter logic [DATA_W*SYNC_WORDS-1:0] SYNC_PATTERN = 60'hFFC00FFC00FFFFF,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4,
  localparam int OFS_W = DATA_W > 1 ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              realign,
  input  logic [DATA_W-1:0] rdat,
  output logic [DATA_W-1:0] wdat,
  output logic              wdat_valid,
  output logic [OFS_W-1:0]  offset,
  output logic [1:0]        state,
  output logic              sync_hit,
  output logic              lock_lost
);
  localparam int PW = DATA_W * SYNC_WORDS;
  localparam int SR_W = PW + DATA_W;
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(LOSS_CNT + 1);
  localparam logic [MC_W-1:0] LOCK_V = MC_W'(LOCK_CNT);
  localparam logic [MS_W-1:0] LOSS_V = MS_W'(LOSS_CNT);
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;
  state_t st;
  logic [SR_W-1:0] sr;
  logic [DATA_W-1:0] hit_vec, hit_next, wdat_next;
  logic [OFS_W-1:0] hit_ofs;
  logic [MC_W-1:0] mc, mc_inc;
  logic [MS_W-1:0] ms, ms_inc;
  logic hit_at;
  always_comb begin
    hit_next = '0;
    wdat_next = '0;
    hit_ofs = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      hit_next[i] = sr[i +: PW] == SYNC_PATTERN;
      if (offset == OFS_W'(i)) wdat_next = sr[i + PW - DATA_W +: DATA_W];
      if (hit_vec[i]) hit_ofs = OFS_W'(i);
    end
  end
  assign hit_at = |(hit_vec & (DATA_W'(1) << offset));
  assign mc_inc = mc == LOCK_V ? mc : mc + 1'b1;
  assign ms_inc = ms == LOSS_V ? ms : ms + 1'b1;
  assign state = st;
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
      hit_vec <= '0;
      sync_hit <= 1'b0;
      wdat <= '0;
      offset <= '0;
      mc <= '0;
      ms <= '0;
      st <= HUNT;
      wdat_valid <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      sr <= {sr[SR_W-DATA_W-1:0], rdat};
      hit_vec <= hit_next;
      sync_hit <= |hit_next;
      wdat <= wdat_next;
      lock_lost <= 1'b0;
      if (realign) begin
        st <= HUNT;
        mc <= '0;
        ms <= '0;
        wdat_valid <= 1'b0;
        lock_lost <= st == LOCKED;
      end else if (|hit_vec) begin
        case (st)
          HUNT: begin
            offset <= hit_ofs;
            mc <= MC_W'(1);
            st <= LOCK_CNT == 1 ? LOCKED : VERIFY;
            wdat_valid <= LOCK_CNT == 1;
          end
          VERIFY: begin
            if (hit_at) begin
              mc <= mc_inc;
              if (mc_inc == LOCK_V) begin
                st <= LOCKED;
                wdat_valid <= 1'b1;
              end
            end else begin
              offset <= hit_ofs;
              mc <= MC_W'(1);
            end
          end
          LOCKED: begin
            if (hit_at) ms <= '0;
            else if (ms_inc == LOSS_V) begin
              st <= HUNT;
              ms <= '0;
              mc <= '0;
              wdat_valid <= 1'b0;
              lock_lost <= 1'b1;
            end else ms <= ms_inc;
          end
          default: st <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tcm_receiver_wordalign.sv
// tb_tcm_receiver_wordalign: bit-stream reference model plus scenario table for the word aligner
module tb_tcm_receiver_wordalign;
  localparam int DW = 10, PW = 60, SRW = 70;
  logic clk = 1'b0, reset = 1'b0, realign = 1'b0;
  logic [9:0] rdat = '0, wdat;
  logic wdat_valid, sync_hit, lock_lost;
  logic [3:0] offset;
  logic [1:0] state;
  logic reset2 = 1'b0, realign2 = 1'b0;
  logic [7:0] rdat2 = '0, wdat2;
  logic valid2, hit2, lost2;
  logic [2:0] offset2;
  logic [1:0] state2;
  logic [59:0] pat = 60'hFFC00FFC00FFFFF;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  tcm_receiver_wordalign dut (.clk(clk), .reset(reset), .realign(realign), .rdat(rdat), .wdat(wdat),
    .wdat_valid(wdat_valid), .offset(offset), .state(state), .sync_hit(sync_hit), .lock_lost(lock_lost));
  tcm_receiver_wordalign #(.DATA_W(8), .SYNC_WORDS(4), .SYNC_PATTERN(32'hF0F0FF00), .LOCK_CNT(1)) dut2 (
    .clk(clk), .reset(reset2), .realign(realign2), .rdat(rdat2), .wdat(wdat2), .wdat_valid(valid2),
    .offset(offset2), .state(state2), .sync_hit(hit2), .lock_lost(lost2));
  bit sbits[$];
  bit pend[$];
  logic [9:0] m_hv, m_wdat;
  bit m_sh, m_lost, m_val;
  int m_st, m_ofs, m_mc, m_ms;
  typedef struct { int ofs; bit rl; int st; int o; bit lost; } vec_t;
  vec_t tbl[22];
  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit sb(int idx);
    return (idx >= 0 && idx < sbits.size()) ? sbits[idx] : 1'b0;
  endfunction
  task automatic model_step(bit rst, bit rl, logic [9:0] rd);
    logic [9:0] nhv, nw;
    int last, h;
    bit ok;
    if (rst) begin
      sbits.delete();
      m_hv = '0; m_wdat = '0; m_sh = 0; m_lost = 0; m_val = 0;
      m_st = 0; m_ofs = 0; m_mc = 0; m_ms = 0;
      return;
    end
    last = sbits.size() - 1;
    for (int k = 0; k < DW; k++) begin
      ok = 1;
      for (int q = 0; q < PW; q++) if (sb(last - k - q) != pat[q]) ok = 0;
      nhv[k] = ok;
    end
    for (int j = 0; j < DW; j++) nw[j] = sb(last - (m_ofs + PW - DW + j));
    m_lost = 0;
    if (rl) begin
      m_lost = m_st == 2;
      m_st = 0; m_mc = 0; m_ms = 0;
    end else if (m_hv != 0) begin
      h = 0;
      while (!m_hv[h]) h++;
      if (m_st == 0) begin
        m_ofs = h; m_mc = 1; m_st = 1;
      end else if (m_st == 1) begin
        if (m_hv[m_ofs]) begin
          m_mc++;
          if (m_mc >= 3) m_st = 2;
        end else begin
          m_ofs = h; m_mc = 1;
        end
      end else if (m_hv[m_ofs]) m_ms = 0;
      else begin
        m_ms++;
        if (m_ms >= 4) begin
          m_st = 0; m_ms = 0; m_mc = 0; m_lost = 1;
        end
      end
    end
    m_val = m_st == 2;
    m_hv = nhv; m_sh = |nhv; m_wdat = nw;
    for (int j = DW - 1; j >= 0; j--) sbits.push_back(rd[j]);
    while (sbits.size() > SRW) void'(sbits.pop_front());
  endtask
  task automatic send_word(logic [9:0] rd, bit rl);
    rdat = rd;
    realign = rl;
    @(posedge clk);
    model_step(reset, rl, rd);
    #1;
    check("wdat", int'(wdat), int'(m_wdat));
    check("wdat_valid", int'(wdat_valid), int'(m_val));
    check("offset", int'(offset), m_ofs);
    check("state", int'(state), m_st);
    check("sync_hit", int'(sync_hit), int'(m_sh));
    check("lock_lost", int'(lock_lost), int'(m_lost));
    realign = 1'b0;
  endtask
  task automatic push_rand(int n);
    for (int i = 0; i < n; i++) pend.push_back(bit'($urandom_range(1)));
  endtask
  task automatic flush();
    logic [9:0] w;
    while (pend.size() >= DW) begin
      for (int j = DW - 1; j >= 0; j--) w[j] = pend.pop_front();
      send_word(w, 1'b0);
    end
  endtask
  task automatic place(int k);
    int tot;
    tot = pend.size() + 2 * DW + PW + k;
    push_rand(2 * DW + (DW - tot % DW) % DW);
    for (int q = PW - 1; q >= 0; q--) pend.push_back(pat[q]);
    push_rand(k);
    flush();
  endtask
  task automatic run_vec(vec_t v);
    place(v.ofs);
    send_word(10'($urandom), 1'b0);
    check("tbl_hit", int'(sync_hit), 1);
    send_word(10'($urandom), v.rl);
    check("tbl_state", int'(state), v.st);
    check("tbl_offset", int'(offset), v.o);
    check("tbl_lost", int'(lock_lost), int'(v.lost));
    check("tbl_valid", int'(wdat_valid), int'(v.st == 2));
    send_word(10'($urandom), 1'b0);
    check("tbl_lost_pulse", int'(lock_lost), 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    send_word(10'($urandom), 1'b0);
    reset = 1'b0;
    check("rst_state", int'(state), 0);
    check("rst_offset", int'(offset), 0);
    check("rst_wdat", int'(wdat), 0);
    check("rst_valid", int'(wdat_valid), 0);
    check("rst_hit", int'(sync_hit), 0);
    check("rst_lost", int'(lock_lost), 0);
  endtask
  initial begin
    logic [63:0] v;
    int r;
    tbl[0] = '{3, 1'b0, 1, 3, 1'b0};
    tbl[1] = '{3, 1'b0, 1, 3, 1'b0};
    tbl[2] = '{3, 1'b0, 2, 3, 1'b0};
    tbl[3] = '{7, 1'b0, 2, 3, 1'b0};
    tbl[4] = '{7, 1'b0, 2, 3, 1'b0};
    tbl[5] = '{3, 1'b0, 2, 3, 1'b0};
    tbl[6] = '{7, 1'b0, 2, 3, 1'b0};
    tbl[7] = '{7, 1'b0, 2, 3, 1'b0};
    tbl[8] = '{7, 1'b0, 2, 3, 1'b0};
    tbl[9] = '{7, 1'b0, 0, 3, 1'b1};
    tbl[10] = '{7, 1'b0, 1, 7, 1'b0};
    tbl[11] = '{2, 1'b0, 1, 2, 1'b0};
    tbl[12] = '{2, 1'b0, 1, 2, 1'b0};
    tbl[13] = '{5, 1'b0, 1, 5, 1'b0};
    tbl[14] = '{5, 1'b0, 1, 5, 1'b0};
    tbl[15] = '{5, 1'b0, 2, 5, 1'b0};
    tbl[16] = '{5, 1'b1, 0, 5, 1'b1};
    tbl[17] = '{0, 1'b0, 1, 0, 1'b0};
    tbl[18] = '{9, 1'b0, 1, 9, 1'b0};
    tbl[19] = '{4, 1'b0, 1, 4, 1'b0};
    tbl[20] = '{4, 1'b0, 1, 4, 1'b0};
    tbl[21] = '{4, 1'b0, 2, 4, 1'b0};
    do_reset();
    for (int i = 0; i < 22; i++) run_vec(tbl[i]);
    do_reset();
    for (int i = 0; i < 5; i++) send_word(10'($urandom), 1'b0);
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(99);
      if (r < 55) place(r < 30 ? 3 : $urandom_range(9));
      else if (r < 65) send_word(10'($urandom), 1'b1);
      else if (r < 69) do_reset();
      else send_word(10'($urandom), 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      reset2 = 1'b1;
      @(posedge clk);
      #1;
      reset2 = 1'b0;
      check("w8_rst_state", int'(state2), 0);
      v = (64'(32'hF0F0FF00) << k) | (64'($urandom) & ((64'd1 << k) - 64'd1));
      for (int w = 7; w >= 0; w--) begin
        rdat2 = v[w*8 +: 8];
        @(posedge clk);
        #1;
      end
      rdat2 = '0;
      @(posedge clk);
      #1;
      check("w8_hit", int'(hit2), 1);
      @(posedge clk);
      #1;
      check("w8_state", int'(state2), 2);
      check("w8_offset", int'(offset2), k);
      check("w8_valid", int'(valid2), 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
